// File: rtl/mem_requester.sv
// NOC initiator that turns single load/store client requests into memory
// request packets and waits for the matching reply, one transaction at a time.

package mem_requester_pkg;
   localparam int unsigned NOC_ADDR_W = 8;
   localparam int unsigned NOC_PRT_W  = 4;
   localparam int unsigned PKT_PT_W   = 4;
   localparam int unsigned PKT_ID_W   = 8;
   localparam int unsigned PKT_DAT_W  = 128;

   localparam logic [PKT_PT_W-1:0] PT_MEM_RD_REQ = 4'd1;
   localparam logic [PKT_PT_W-1:0] PT_MEM_WR_REQ = 4'd2;
   localparam logic [PKT_PT_W-1:0] PT_MEM_RD_REP = 4'd3;
   localparam logic [PKT_PT_W-1:0] PT_MEM_WR_REP = 4'd4;

   typedef struct packed {
      logic [PKT_PT_W-1:0]   pt;
      logic [PKT_ID_W-1:0]   id;
      logic [NOC_ADDR_W-1:0] dst_addr;
      logic [NOC_PRT_W-1:0]  dst_prt;
      logic [NOC_ADDR_W-1:0] src_addr;
      logic [NOC_PRT_W-1:0]  src_prt;
      logic [PKT_DAT_W-1:0]  dat;
   } noc_pkt_t;
endpackage

module mem_requester
   import mem_requester_pkg::*;
#(
   parameter logic [NOC_ADDR_W-1:0] MEM_ADDR = '0,
   parameter logic [NOC_PRT_W-1:0]  MEM_PRT  = '0,
   parameter int unsigned           ID_W     = 8,
   parameter int unsigned           TIMEOUT  = 1024
) (
   input  logic                  mclk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [PKT_DAT_W-1:0]  resp_rdata,
   output logic                  resp_err,
   input  logic [NOC_ADDR_W-1:0] port_address,
   input  logic [NOC_PRT_W-1:0]  port_number,
   output noc_pkt_t              dat_to_noc,
   output logic                  tx_submit,
   input  logic                  tx_complete,
   input  noc_pkt_t              dat_from_noc,
   input  logic                  rx_recieve,
   output logic                  rx_complete,
   output logic [15:0]           drop_cnt
);

   // One spare bit so the timer cannot wrap while it sits at TIMEOUT across an RXGAP.
   localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) + 1 : 1;

   typedef enum logic [2:0] {IDLE, SEND, WAIT, RXGAP, DONE} state_t;

   state_t                state_q, state_d;
   logic [ID_W-1:0]       id_q, id_d;
   logic [TMR_W-1:0]      timer_q, timer_d;
   logic                  we_q, we_d;
   noc_pkt_t              pkt_d;
   logic                  req_ready_d, resp_valid_d, resp_err_d;
   logic                  tx_submit_d, rx_complete_d;
   logic [PKT_DAT_W-1:0]  resp_rdata_d;
   logic [15:0]           drop_cnt_d;
   logic                  rx_match;
   logic                  unused_rx;

   assign unused_rx = ^{dat_from_noc.dst_addr, dat_from_noc.dst_prt,
                        dat_from_noc.src_addr, dat_from_noc.src_prt};

   // Next state and next values of every registered output.
   always_comb begin
      state_d       = state_q;
      id_d          = id_q;
      timer_d       = timer_q;
      we_d          = we_q;
      pkt_d         = dat_to_noc;
      tx_submit_d   = 1'b0;
      rx_complete_d = 1'b0;
      resp_valid_d  = 1'b0;
      resp_err_d    = 1'b0;
      resp_rdata_d  = resp_rdata;
      drop_cnt_d    = drop_cnt;
      rx_match      = rx_recieve &&
                      (dat_from_noc.pt == (we_q ? PT_MEM_WR_REP : PT_MEM_RD_REP)) &&
                      (dat_from_noc.id == PKT_ID_W'(id_q));

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               pkt_d.pt       = req_we ? PT_MEM_WR_REQ : PT_MEM_RD_REQ;
               pkt_d.id       = PKT_ID_W'(id_q);
               pkt_d.dst_addr = MEM_ADDR;
               pkt_d.dst_prt  = MEM_PRT;
               pkt_d.src_addr = port_address;
               pkt_d.src_prt  = port_number;
               pkt_d.dat      = {64'h0, (req_we ? req_wdata : 32'h0), req_addr};
               we_d           = req_we;
               tx_submit_d    = 1'b1;
               state_d        = SEND;
            end
         end
         SEND: begin
            tx_submit_d = 1'b1;
            if (tx_complete) begin
               tx_submit_d = 1'b0;
               timer_d     = '0;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            timer_d = timer_q + TMR_W'(1);
            if (rx_match) begin
               rx_complete_d = 1'b1;
               resp_valid_d  = 1'b1;
               resp_rdata_d  = we_q ? '0 : dat_from_noc.dat;
               id_d          = id_q + ID_W'(1);
               state_d       = DONE;
            end else if (rx_recieve) begin
               rx_complete_d = 1'b1;
               if (drop_cnt != 16'hFFFF) drop_cnt_d = drop_cnt + 16'd1;
               state_d       = RXGAP;
            end else if ((TIMEOUT != 0) && (timer_d >= TMR_W'(TIMEOUT))) begin
               resp_valid_d  = 1'b1;
               resp_err_d    = 1'b1;
               resp_rdata_d  = '0;
               id_d          = id_q + ID_W'(1);
               state_d       = DONE;
            end
         end
         RXGAP:   state_d = WAIT;
         DONE:    if (!rx_recieve) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
   end

   // State and output registers.
   always_ff @(posedge mclk) begin
      if (rst) begin
         state_q     <= IDLE;
         id_q        <= '0;
         timer_q     <= '0;
         we_q        <= 1'b0;
         dat_to_noc  <= '0;
         req_ready   <= 1'b0;
         tx_submit   <= 1'b0;
         rx_complete <= 1'b0;
         resp_valid  <= 1'b0;
         resp_err    <= 1'b0;
         resp_rdata  <= '0;
         drop_cnt    <= '0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         timer_q     <= timer_d;
         we_q        <= we_d;
         dat_to_noc  <= pkt_d;
         req_ready   <= req_ready_d;
         tx_submit   <= tx_submit_d;
         rx_complete <= rx_complete_d;
         resp_valid  <= resp_valid_d;
         resp_err    <= resp_err_d;
         resp_rdata  <= resp_rdata_d;
         drop_cnt    <= drop_cnt_d;
      end
   end

endmodule
